// File: rtl/adc_ramp_check_multi_pkg.sv
// ============================================================================
// Module  : adc_ramp_check_multi_pkg
// Brief   : Shared state encoding and lane/slice helpers for the ramp checker.
// Revision: 1.0
// ============================================================================
`default_nettype none

package adc_ramp_check_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Each core delivers an H and an L sample per path.
    function automatic int lanes_of(input int paths);
        return 2 * paths;
    endfunction

    // LSB position of (channel, lane) inside the flattened data bus.
    function automatic int slice_lsb(input int ch, input int lane, input int lanes, input int width);
        return (ch * lanes + lane) * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_ramp_check_lane.sv
// ============================================================================
// Module  : adc_ramp_check_lane
// Brief   : Per-channel two-stage ramp checker with saturating error counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adc_ramp_check_lane #(
    parameter int ADC_DATA_WIDTH = 8,
    parameter int LANES          = 8,
    parameter int RAMP_STEP      = 1,
    parameter int CNT_W          = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic                            cap_i,
    input  logic                            first_i,
    input  logic                            done_i,
    input  logic [LANES*ADC_DATA_WIDTH-1:0] word_i,
    output logic                            ok_o,
    output logic [CNT_W-1:0]                err_cnt_o
);

    localparam int W = ADC_DATA_WIDTH;
    localparam logic [W-1:0] C_STEP = W'(RAMP_STEP);

    logic [LANES*W-1:0] word_q, word_d;
    logic [W-1:0]       prev_q, prev_d;
    logic               v1_q, v1_d;
    logic               first1_q, first1_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic               ok_q, ok_d;
    logic               w_fail;

    always_comb begin
        w_fail = 1'b0;
        for (int k = 0; k < LANES - 1; k++) begin
            if (word_q[(k+1)*W +: W] != W'(word_q[k*W +: W] + C_STEP)) begin
                w_fail = 1'b1;
            end
        end
        if (!first1_q && (word_q[0 +: W] != W'(prev_q + C_STEP))) begin
            w_fail = 1'b1;
        end
    end

    always_comb begin
        word_d   = word_q;
        prev_d   = prev_q;
        v1_d     = cap_i;
        first1_d = first_i;
        err_d    = err_q;
        ok_d     = ok_q;

        // Stage 1: the word being replaced supplies the previous last sample.
        if (cap_i) begin
            word_d = word_i;
            prev_d = word_q[(LANES-1)*W +: W];
        end

        if (v1_q && w_fail && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + CNT_W'(1);
        end

        if (done_i) begin
            ok_d = (err_q == '0);
        end

        if (start_i) begin
            err_d = '0;
            ok_d  = 1'b0;
            v1_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q   <= '0;
            prev_q   <= '0;
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            err_q    <= '0;
            ok_q     <= 1'b0;
        end else begin
            word_q   <= word_d;
            prev_q   <= prev_d;
            v1_q     <= v1_d;
            first1_q <= first1_d;
            err_q    <= err_d;
            ok_q     <= ok_d;
        end
    end

    assign ok_o      = ok_q;
    assign err_cnt_o = err_q;

endmodule

`default_nettype wire

// File: rtl/adc_ramp_check_multi.sv
// ============================================================================
// Module  : adc_ramp_check_multi
// Brief   : Multi-channel ADC test-ramp checker: run FSM plus one lane per channel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adc_ramp_check_multi
    import adc_ramp_check_multi_pkg::*;
#(
    parameter int ADC_DATA_WIDTH    = 8,
    parameter int PARALLEL_PATH_NUM = 4,
    parameter int NUM_CHANNELS      = 4,
    parameter int CHECK_CYCLES      = 256,
    parameter int RAMP_STEP         = 1,
    parameter int CNT_W             = 16
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     detect_in,
    input  logic [NUM_CHANNELS*2*PARALLEL_PATH_NUM*ADC_DATA_WIDTH-1:0] adc_data_i,
    output logic                                                     check_busy,
    output logic                                                     check_done,
    output logic [NUM_CHANNELS-1:0]                                  ramp_ok_o,
    output logic [NUM_CHANNELS*CNT_W-1:0]                            err_cnt_o
);

    localparam int LANES = lanes_of(PARALLEL_PATH_NUM);
    localparam int CW    = $clog2(CHECK_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CHECK_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          det_q, det_d;
    logic          armed_q, armed_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          w_start;
    logic          w_cap;
    logic          w_first;
    logic          w_done;

    // A level left high across reset must be dropped once before it can start a run.
    assign w_start = (state_q == ST_IDLE) && detect_in && !det_q && armed_q;
    assign w_cap   = (state_q == ST_ARM) || ((state_q == ST_CHECK) && (cnt_q != C_LAST));
    assign w_first = (state_q == ST_ARM);
    assign w_done  = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        det_d   = detect_in;
        armed_d = armed_q | ~detect_in;
        busy_d  = (state_q == ST_ARM) || (state_q == ST_CHECK);
        done_d  = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                state_d = ST_CHECK;
                cnt_d   = '0;
            end
            ST_CHECK: begin
                if (cnt_q == C_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            det_q   <= 1'b0;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            det_q   <= det_d;
            armed_q <= armed_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign check_busy = busy_q;
    assign check_done = done_q;

    generate
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
            adc_ramp_check_lane #(
                .ADC_DATA_WIDTH (ADC_DATA_WIDTH),
                .LANES          (LANES),
                .RAMP_STEP      (RAMP_STEP),
                .CNT_W          (CNT_W)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .start_i   (w_start),
                .cap_i     (w_cap),
                .first_i   (w_first),
                .done_i    (w_done),
                .word_i    (adc_data_i[slice_lsb(c, 0, LANES, ADC_DATA_WIDTH) +: LANES*ADC_DATA_WIDTH]),
                .ok_o      (ramp_ok_o[c]),
                .err_cnt_o (err_cnt_o[c*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_adc_ramp_check_multi.sv
// ============================================================================
// Module  : tb_adc_ramp_check_multi
// Brief   : Directed self-checking bench for adc_ramp_check_multi.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_adc_ramp_check_multi;

    localparam int N  = 16;
    localparam int N2 = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         detect;
    logic [255:0] data;
    logic         check_busy, check_done;
    logic [3:0]   ramp_ok_o;
    logic [63:0]  err_cnt_o;

    logic         detect2;
    logic [255:0] data2;
    logic         busy2, done2;
    logic [3:0]   ok2;
    logic [15:0]  err2;

    int checks   = 0;
    int failures = 0;

    int base [4];
    int skip_ch, skip_w, cor_ch, cor_w, cor_l;
    int busy_bad, done_cnt, done_at;
    logic [3:0]  snap_ok;
    logic [63:0] snap_err;

    always #5 clk = ~clk;

    adc_ramp_check_multi #(
        .ADC_DATA_WIDTH(8), .PARALLEL_PATH_NUM(4), .NUM_CHANNELS(4),
        .CHECK_CYCLES(N), .RAMP_STEP(1), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .detect_in(detect), .adc_data_i(data),
        .check_busy(check_busy), .check_done(check_done),
        .ramp_ok_o(ramp_ok_o), .err_cnt_o(err_cnt_o)
    );

    adc_ramp_check_multi #(
        .ADC_DATA_WIDTH(8), .PARALLEL_PATH_NUM(4), .NUM_CHANNELS(4),
        .CHECK_CYCLES(N2), .RAMP_STEP(1), .CNT_W(4)
    ) dut2 (
        .clk(clk), .rst(rst), .detect_in(detect2), .adc_data_i(data2),
        .check_busy(busy2), .check_done(done2),
        .ramp_ok_o(ok2), .err_cnt_o(err2)
    );

    function automatic logic [255:0] gen_word(input int w);
        logic [255:0] r;
        int tmp;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < 8; l++) begin
                tmp = base[c] + w * 8 + l;
                if (c == skip_ch && w >= skip_w) tmp = tmp + 1;
                if (c == cor_ch && w == cor_w && l == cor_l) tmp = tmp + 1;
                r[(c*8+l)*8 +: 8] = tmp[7:0];
            end
        end
        return r;
    endfunction

    task automatic set_defaults();
        base[0] = 'h10; base[1] = 'h37; base[2] = 'h80; base[3] = 'hC5;
        skip_ch = -1; skip_w = 0; cor_ch = -1; cor_w = 0; cor_l = 0;
    endtask

    // Start edge T is the posedge right after detect rises; e counts edges after T.
    task automatic do_run();
        busy_bad = 0; done_cnt = 0; done_at = -1;
        @(negedge clk);
        detect = 1'b1;
        for (int e = 0; e <= N + 4; e++) begin
            @(negedge clk);
            data = gen_word(e);
            if (check_busy !== ((e >= 1 && e <= N + 1) ? 1'b1 : 1'b0)) busy_bad++;
            if (check_done === 1'b1) begin
                done_cnt++;
                done_at = e;
            end
            if (e == N + 2) begin
                snap_ok  = ramp_ok_o;
                snap_err = err_cnt_o;
            end
        end
        detect = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; detect = 1'b0; detect2 = 1'b0; data = '0; data2 = '0;
        repeat (2) @(negedge clk);
        checks++; if (check_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", check_busy); end
        checks++; if (check_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", check_done); end
        checks++; if (ramp_ok_o !== 4'b0) begin failures++; $display("FAIL reset_ok got=%b want=0000", ramp_ok_o); end
        checks++; if (err_cnt_o !== 64'd0) begin failures++; $display("FAIL reset_err got=%h want=0", err_cnt_o); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ideal();
        set_defaults();
        do_run();
        checks++; if (busy_bad !== 0) begin failures++; $display("FAIL ideal_busy_timing bad_cycles=%0d want=0", busy_bad); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ideal_done_count got=%0d want=1", done_cnt); end
        checks++; if (done_at !== N + 2) begin failures++; $display("FAIL ideal_done_latency got=%0d want=%0d", done_at, N + 2); end
        checks++; if (snap_ok !== 4'b1111) begin failures++; $display("FAIL ideal_ok got=%b want=1111", snap_ok); end
        checks++; if (snap_err !== 64'd0) begin failures++; $display("FAIL ideal_err got=%h want=0", snap_err); end
    endtask

    task automatic test_wrap();
        set_defaults();
        base[0] = 'hFE;
        base[1] = 'hF8;
        do_run();
        checks++; if (done_at !== N + 2) begin failures++; $display("FAIL wrap_done_latency got=%0d want=%0d", done_at, N + 2); end
        checks++; if (snap_ok !== 4'b1111) begin failures++; $display("FAIL wrap_ok got=%b want=1111", snap_ok); end
        checks++; if (snap_err !== 64'd0) begin failures++; $display("FAIL wrap_err got=%h want=0", snap_err); end
    endtask

    task automatic test_intra_error();
        set_defaults();
        cor_ch = 2; cor_w = 5; cor_l = 3;
        do_run();
        checks++; if (snap_ok !== 4'b1011) begin failures++; $display("FAIL intra_ok got=%b want=1011", snap_ok); end
        checks++; if (snap_err !== {16'd0, 16'd1, 16'd0, 16'd0}) begin failures++; $display("FAIL intra_err got=%h want=0000000100000000", snap_err); end
        // results hold after the done pulse until the next start
        checks++; if (ramp_ok_o !== 4'b1011) begin failures++; $display("FAIL intra_ok_hold got=%b want=1011", ramp_ok_o); end
    endtask

    task automatic test_inter_error();
        set_defaults();
        skip_ch = 0; skip_w = 8;
        do_run();
        checks++; if (snap_ok !== 4'b1110) begin failures++; $display("FAIL inter_ok got=%b want=1110", snap_ok); end
        checks++; if (snap_err !== {16'd0, 16'd0, 16'd0, 16'd1}) begin failures++; $display("FAIL inter_err got=%h want=0000000000000001", snap_err); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL inter_done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_saturate();
        int dcnt;
        logic [3:0]  s_ok;
        logic [15:0] s_err;
        dcnt = 0; s_ok = '1; s_err = '0;
        data2 = '0;
        @(negedge clk);
        detect2 = 1'b1;
        for (int e = 0; e <= N2 + 3; e++) begin
            @(negedge clk);
            if (done2 === 1'b1) dcnt++;
            if (e == N2 + 2) begin
                s_ok  = ok2;
                s_err = err2;
            end
        end
        detect2 = 1'b0;
        checks++; if (dcnt !== 1) begin failures++; $display("FAIL sat_done_count got=%0d want=1", dcnt); end
        checks++; if (s_err !== 16'hFFFF) begin failures++; $display("FAIL sat_err got=%h want=ffff", s_err); end
        checks++; if (s_ok !== 4'b0000) begin failures++; $display("FAIL sat_ok got=%b want=0000", s_ok); end
    endtask

    task automatic test_reset_mid_run();
        int bcnt, dcnt;
        set_defaults();
        @(negedge clk);
        detect = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            data = gen_word(e);
        end
        rst = 1'b1;
        #1;
        checks++; if (check_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", check_busy); end
        checks++; if ({ramp_ok_o, err_cnt_o} !== 68'd0) begin failures++; $display("FAIL midrst_results got=%h want=0", {ramp_ok_o, err_cnt_o}); end
        @(negedge clk);
        rst = 1'b0;
        bcnt = 0; dcnt = 0;
        for (int e = 0; e < N + 6; e++) begin
            @(negedge clk);
            if (check_busy === 1'b1) bcnt++;
            if (check_done === 1'b1) dcnt++;
        end
        checks++; if (bcnt !== 0) begin failures++; $display("FAIL held_no_restart busy_cycles=%0d want=0", bcnt); end
        checks++; if (dcnt !== 0) begin failures++; $display("FAIL held_no_done done_cycles=%0d want=0", dcnt); end
        detect = 1'b0;
        @(negedge clk);
        do_run();
        checks++; if (busy_bad !== 0) begin failures++; $display("FAIL rerun_busy_timing bad_cycles=%0d want=0", busy_bad); end
        checks++; if (done_at !== N + 2) begin failures++; $display("FAIL rerun_done_latency got=%0d want=%0d", done_at, N + 2); end
        checks++; if (snap_ok !== 4'b1111) begin failures++; $display("FAIL rerun_ok got=%b want=1111", snap_ok); end
        checks++; if (snap_err !== 64'd0) begin failures++; $display("FAIL rerun_err got=%h want=0", snap_err); end
    endtask

    initial begin
        set_defaults();
        test_reset();
        test_ideal();
        test_wrap();
        test_intra_error();
        test_inter_error();
        test_saturate();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
